divu_seq: RTL
=============

Name: divu_seq

Overview:
- Sequential unsigned divider that sits directly upstream of the Hi/Lo register stage of the ALU datapath.
- Accepts a DIVU request (Signal = 27) with dataA / dataB.
- Runs a restoring shift-subtract loop of one quotient bit per clock.
- Delivers quotient (to Lo) and remainder (to Hi) with a one-cycle write strobe that the following MFHI (16) / MFLO (18) reads depend on.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (reset = 0 clears all state immediately).
- start  input  1  request pulse; sampled only in IDLE.
- dataA  input  WIDTH  dividend, unsigned.
- dataB  input  WIDTH  divisor, unsigned.
- busy  output  1  high from the accept edge until DONE is left.
- done  output  1  one-cycle pulse, results valid.
- hilo_we  output  1  write strobe to Hi/Lo stage; identical timing to done.
- hi  output  WIDTH  remainder.
- lo  output  WIDTH  quotient.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE, counter = 0, internal remainder/quotient registers = 0.
  - busy = 0, done = 0, hilo_we = 0, hi = 0, lo = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - On the edge where start = 1: latch dataA into the quotient/shift register, dataB into the divisor register, clear the WIDTH+1-bit partial remainder, set counter = 0.
  - Go to RUN; busy = 1 from this edge.
  - start = 0: stay in IDLE; hi/lo hold their last values.
- RUN, one iteration per edge:
  - R = {R[WIDTH-1:0], Q[WIDTH-1]}; Q = Q << 1.
  - If R >= {1'b0, D}: R = R - D and Q[0] = 1, else Q[0] = 0.
  - counter++.
  - After the WIDTH-th iteration (counter reaches WIDTH), go to DONE.
- DONE, exactly one cycle:
  - done = 1, hilo_we = 1.
  - hi = R[WIDTH-1:0] and lo = Q, both registered on the DONE-entry edge.
  - Next edge: IDLE, busy = 0, done = 0.
- Latency:
  - Request accepted at edge N → DONE entered at edge N+WIDTH+1 (N+33 for WIDTH = 32).
  - IDLE again at edge N+WIDTH+2.
  - Back-to-back: a new start is accepted no earlier than the first IDLE cycle.
- start while busy (RUN or DONE): ignored; no queuing; operands in flight are unaffected by changes on dataA/dataB.
- hi/lo hold their values indefinitely until the next DONE. They are never cleared by start; only reset clears them.
- Divide by zero (dataB = 0):
  - No special path; full latency still applies.
  - Algorithm yields lo = all ones (0xFFFFFFFF), hi = dataA.
- dataA < dataB: lo = 0, hi = dataA.
- reset asserted mid-RUN: operation aborted, all outputs to reset values; no done/hilo_we pulse is produced.
- All arithmetic is unsigned; the partial remainder is WIDTH+1 bits so the compare never overflows.

Optional Feature:
- Macro: DIVU_DIVZERO_FLAG_EN.
- Defined:
  - Extra output port div_zero (1 bit), registered on the accept edge as (dataB == 0).
  - Held until the next accepted start; reset value 0.
  - In DONE with div_zero = 1, hilo_we is suppressed (forced 0) so Hi/Lo keep prior contents; done still pulses, and hi/lo outputs still show all ones / dataA.
- Not defined: no div_zero port; divide by zero behaves exactly as stated in Behaviour, with hilo_we pulsing normally.

Test Plan:
- Reset, then start with dataA = 100, dataB = 7 → busy high for 34 cycles; done/hilo_we single pulse 33 edges after accept; hi = 2, lo = 14.
- dataA = 0xFFFFFFFF, dataB = 1 → lo = 0xFFFFFFFF, hi = 0; then dataA = 5, dataB = 9 → lo = 0, hi = 5.
- dataA = 1234, dataB = 0 → lo = 0xFFFFFFFF, hi = 1234. With DIVU_DIVZERO_FLAG_EN: div_zero = 1 and hilo_we stays 0 during done.
- Accept dataA = 50, dataB = 5; pulse start with dataA = 9, dataB = 3 and change operands at cycle 10 → second start ignored; result hi = 0, lo = 10; next start in IDLE gives hi = 0, lo = 3.
- Drive reset = 0 at cycle 15 of RUN (dataA = 77, dataB = 4) → busy, done, hilo_we, hi, lo all 0 immediately (asynchronously); no done pulse; a fresh run after release gives hi = 1, lo = 19.
- Random 1000 operand pairs including dataB = 1, dataA = dataB, and dataB = 0x80000000 → hi/lo match reference dataA % dataB and dataA / dataB.

Source files
------------

// File: rtl/divu_seq.sv
// Sequential restoring unsigned divider feeding the Hi/Lo register stage.
// Optional DIVU_DIVZERO_FLAG_EN adds a div_zero flag and suppresses hilo_we on /0.
module divu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
`ifdef DIVU_DIVZERO_FLAG_EN
    output logic             div_zero,
`endif
    output logic             busy,
    output logic             done,
    output logic             hilo_we,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

`ifdef DIVU_DIVZERO_FLAG_EN
    logic dz_q, dz_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef DIVU_DIVZERO_FLAG_EN
        dz_d    = dz_q;
`endif
        shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, div_q};
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    quo_d   = dataA;
                    div_d   = dataB;
                    rem_d   = '0;
                    cnt_d   = '0;
`ifdef DIVU_DIVZERO_FLAG_EN
                    dz_d    = (dataB == '0);
`endif
                end
            end
            RUN: begin
                // counter == WIDTH means all quotient bits are formed
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    hi_d    = rem_q[WIDTH-1:0];
                    lo_d    = quo_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (shifted >= {1'b0, div_q}) begin
                        rem_d = diff;
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shifted;
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

`ifdef DIVU_DIVZERO_FLAG_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dz_q <= 1'b0;
        end else begin
            dz_q <= dz_d;
        end
    end

    // a /0 result must not overwrite Hi/Lo
    assign div_zero = dz_q;
    assign hilo_we  = done & ~dz_q;
`else
    assign hilo_we  = done;
`endif

endmodule
